// File: rtl/score_display.sv
// score_display: binary score -> BCD (double dabble) and scaled 3x5 glyph renderer.
// Ports: clk, reset, score/score_valid in, busy/bcd_out out, hcount/vcount in, in_region/rgb out.
module score_display #(
    parameter int          NUM_DIGITS = 4,
    parameter int          SCORE_W    = 14,
    parameter int          SCALE_LOG2 = 2,
    parameter int          GAP        = 1,
    parameter int          ORIGIN_X   = 400,
    parameter int          ORIGIN_Y   = 40,
    parameter logic [23:0] FG_COLOR   = 24'h00aa00,
    parameter logic [23:0] BG_COLOR   = 24'h4f223b
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SCORE_W-1:0]      score,
    input  logic                    score_valid,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    input  logic [9:0]              hcount,
    input  logic [9:0]              vcount,
    output logic                    in_region,
    output logic [23:0]             rgb
);
    localparam int BW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int S     = 1 << SCALE_LOG2;
    localparam int CW    = (3 + GAP) * S;
    localparam logic [31:0] LIMIT = 32'(10 ** NUM_DIGITS);
    localparam logic [31:0] X0 = 32'(ORIGIN_X);
    localparam logic [31:0] X1 = 32'(ORIGIN_X + NUM_DIGITS * CW);
    localparam logic [31:0] Y0 = 32'(ORIGIN_Y);
    localparam logic [31:0] Y1 = 32'(ORIGIN_Y + 5 * S);
    localparam logic [9:0]  CWV = 10'(CW);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

    state_t             r_state, w_next;
    logic [SCORE_W-1:0] r_bin, r_pend;
    logic               r_pend_v, r_sat;
    logic [BW-1:0]      r_scr, r_bcd, w_adj;
    logic [CNT_W-1:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (score_valid) w_next = S_LOAD;
            S_LOAD:   w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == CNT_W'(SCORE_W - 1)) w_next = S_COMMIT;
            S_COMMIT: w_next = (score_valid || r_pend_v) ? S_LOAD : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // add-3 correction applied to every scratch nibble before each shift
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_sat    <= 1'b0;
            r_scr    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (score_valid) r_bin <= score;
                S_LOAD: begin
                    r_sat <= (32'(r_bin) >= LIMIT);
                    r_scr <= '0;
                    r_cnt <= '0;
                end
                S_SHIFT: begin
                    {r_scr, r_bin} <= {w_adj[BW-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 1'b1;
                end
                S_COMMIT: begin
                    r_bcd <= r_sat ? {NUM_DIGITS{4'h9}} : r_scr;
                    // a request arriving now is newer than any pending one
                    if (score_valid) begin
                        r_bin    <= score;
                        r_pend_v <= 1'b0;
                    end else if (r_pend_v) begin
                        r_bin    <= r_pend;
                        r_pend_v <= 1'b0;
                    end
                end
                default: ;
            endcase
            if ((r_state == S_LOAD || r_state == S_SHIFT) && score_valid) begin
                r_pend   <= score;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign bcd_out = r_bcd;

    function automatic logic [14:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 15'h7b6f;
            4'd1:    glyph = 15'h2492;
            4'd2:    glyph = 15'h73e7;
            4'd3:    glyph = 15'h73cf;
            4'd4:    glyph = 15'h5bc9;
            4'd5:    glyph = 15'h79cf;
            4'd6:    glyph = 15'h79ef;
            4'd7:    glyph = 15'h7249;
            4'd8:    glyph = 15'h7bef;
            4'd9:    glyph = 15'h7bcf;
            default: glyph = 15'h0000;
        endcase
    endfunction

    logic       w_hit, w_z, w_blank;
    logic [9:0] w_dx, w_dy;
    logic [2:0] w_slot, w_row;
    logic [7:0] w_col;
    logic [3:0] w_dig;

    always_comb begin
        w_hit   = (32'(hcount) >= X0) && (32'(hcount) < X1) &&
                  (32'(vcount) >= Y0) && (32'(vcount) < Y1);
        w_dx    = w_hit ? hcount - 10'(ORIGIN_X) : 10'd0;
        w_dy    = w_hit ? vcount - 10'(ORIGIN_Y) : 10'd0;
        w_slot  = 3'(w_dx / CWV);
        w_col   = 8'((w_dx % CWV) >> SCALE_LOG2);
        w_row   = 3'(w_dy >> SCALE_LOG2);
        w_dig   = 4'd0;
        w_blank = 1'b0;
        // w_z: this slot and every more significant slot are zero
        w_z     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_z = w_z && (r_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            if (w_slot == 3'(i)) begin
                w_dig   = r_bcd[4*(NUM_DIGITS-1-i) +: 4];
                w_blank = w_z && (i != NUM_DIGITS - 1);
            end
        end
    end

    logic       r_s1_hit, r_s1_blank;
    logic [7:0] r_s1_col;
    logic [2:0] r_s1_row;
    logic [3:0] r_s1_dig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_hit   <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s1_col   <= '0;
            r_s1_row   <= '0;
            r_s1_dig   <= '0;
        end else begin
            r_s1_hit   <= w_hit;
            r_s1_blank <= w_blank;
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            r_s1_dig   <= w_dig;
        end
    end

    logic [14:0] w_g;
    logic [4:0]  w_idx;
    logic        w_lit;

    always_comb begin
        w_g   = glyph(r_s1_dig);
        w_idx = 5'(r_s1_row) * 5'd3 + 5'(r_s1_col[2:0]);
        w_lit = 1'b0;
        if (r_s1_hit && !r_s1_blank && r_s1_col < 8'd3 && r_s1_row < 3'd5)
            w_lit = w_g[4'(5'd14 - w_idx)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_region <= 1'b0;
            rgb       <= 24'd0;
        end else begin
            in_region <= r_s1_hit;
            rgb       <= r_s1_hit ? (w_lit ? FG_COLOR : BG_COLOR) : 24'd0;
        end
    end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed + random checks of score_display against an arithmetic model.
// Drives score/score_valid and hcount/vcount; checks busy, bcd_out, in_region, rgb.
module tb_score_display;
    localparam logic [23:0] FG = 24'h00aa00;
    localparam logic [23:0] BG = 24'h4f223b;
    localparam logic [14:0] GL [10] = '{15'h7b6f, 15'h2492, 15'h73e7, 15'h73cf,
        15'h5bc9, 15'h79cf, 15'h79ef, 15'h7249, 15'h7bef, 15'h7bcf};

    logic        clk = 0;
    logic        reset = 0;
    logic [13:0] score = 0;
    logic        score_valid = 0;
    logic        busy;
    logic [15:0] bcd_out;
    logic [9:0]  hcount = 0;
    logic [9:0]  vcount = 0;
    logic        in_region;
    logic [23:0] rgb;

    int n_pass = 0;
    int n_total = 0;
    int disp = 0;

    score_display dut (
        .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
        .busy(busy), .bcd_out(bcd_out), .hcount(hcount), .vcount(vcount),
        .in_region(in_region), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int shown(input int v);
        return (v >= 10000) ? 9999 : v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        int d = shown(v);
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    function automatic logic [24:0] model_pix(input int h, input int v, input int val);
        int dx, dy, slot, col, row, dig, p;
        logic blank, lit;
        logic [14:0] g;
        if (h < 400 || h >= 464 || v < 40 || v >= 60) return 25'd0;
        dx = h - 400; dy = v - 40;
        slot = dx / 16; col = (dx % 16) / 4; row = dy / 4;
        p = pow10(3 - slot);
        dig = (val / p) % 10;
        blank = (val < p) && (slot != 3);
        g = GL[dig];
        lit = !blank && col < 3 && g[14 - (row * 3 + col)];
        return {1'b1, lit ? FG : BG};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        disp = 0;
    endtask

    task automatic convert(input int v, input string tag);
        int cnt = 0;
        @(posedge clk); #1 score = 14'(v); score_valid = 1;
        @(posedge clk); #1 score_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        disp = shown(v);
        chk({tag, "_busy"}, cnt, 16);
        chk({tag, "_bcd"}, 32'(bcd_out), 32'(to_bcd(v)));
    endtask

    task automatic pix(input int h, input int v, input string tag);
        @(posedge clk); #1 hcount = 10'(h); vcount = 10'(v);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk(tag, {7'd0, in_region, rgb}, {7'd0, model_pix(h, v, disp)});
    endtask

    initial begin
        int cnt, sv;
        do_reset();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_reg", {7'd0, in_region, rgb}, 0);

        convert(1234, "c1234");
        pix(400, 40, "p1234_a");
        pix(404, 40, "p1234_b");
        chk("p1234_fg", 32'(rgb), 32'(FG));

        convert(7, "c7");
        pix(400, 40, "p7_s0");
        pix(416, 40, "p7_s1");
        pix(432, 40, "p7_s2");
        pix(448, 40, "p7_s3");
        pix(460, 40, "p7_gap");

        convert(12000, "c12000");
        pix(400, 40, "psat_a");
        pix(404, 48, "psat_b");

        convert(0, "c0");
        pix(400, 40, "p0_s0");
        pix(448, 40, "p0_s3");
        pix(452, 48, "p0_mid");

        pix(399, 40, "edge_l");
        pix(464, 40, "edge_r");
        pix(400, 60, "edge_b");
        pix(400, 59, "edge_in");

        // back-to-back: 5, then 6 and 8 while busy; 6 is overwritten
        @(posedge clk); #1 score = 14'd5; score_valid = 1;
        @(posedge clk); #1 score_valid = 0;
        cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (k == 17) chk("b2b_first", 32'(bcd_out), 32'h0005);
            if (k == 3 || k == 6) begin
                @(posedge clk); #1 score = (k == 3) ? 14'd6 : 14'd8; score_valid = 1;
                @(posedge clk); #1 score_valid = 0;
                k++;
                cnt++;
            end
        end
        chk("b2b_busy", cnt, 32);
        chk("b2b_last", 32'(bcd_out), 32'h0008);
        disp = 8;
        pix(448, 40, "p8");

        // reset partway through a conversion
        @(posedge clk); #1 score = 14'd9999; score_valid = 1;
        @(posedge clk); #1 score_valid = 0;
        repeat (4) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        disp = 0;
        @(negedge clk);
        chk("abort_bcd", 32'(bcd_out), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (30) @(negedge clk);
        chk("abort_late_bcd", 32'(bcd_out), 0);
        chk("abort_late_busy", 32'(busy), 0);

        for (int t = 0; t < 20; t++) begin
            sv = int'($urandom_range(0, 16383));
            if (t % 5 == 0) sv = int'($urandom_range(0, 99));
            convert(sv, "rnd");
            for (int q = 0; q < 3; q++)
                pix(int'($urandom_range(396, 468)), int'($urandom_range(38, 62)), "rnd_pix");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
